of_stage: RTL and testbench
===========================

Name: of_stage

Overview:
- Operand-fetch stage of the 16-bit CPU, directly upstream of the function unit.
- Contains the 8x16 register file, a write-back bypass, a busy-bit scoreboard for RAW/WAW hazards, and one pipeline register.
- Accepts decoded instructions over a valid/ready handshake.
- Presents registered a/b/fs operands, plus the destination tag, to the function unit.

Parameters:
- NREGS, 8, number of architectural registers (address width $clog2(NREGS)).
- DW, 16, datapath width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid_in  in  1  decoded instruction available
- id_ready_out  out  1  stage accepts instruction this cycle
- aa_in  in  3  A source register
- ba_in  in  3  B source register
- mb_in  in  1  1: B operand = const_in, ignore ba_in
- const_in  in  16  immediate
- fs_in  in  fs_t  function select
- rw_in  in  1  instruction writes a register
- da_in  in  3  destination register
- fu_valid_out  out  1  operands valid toward function unit
- fu_ready_in  in  1  function unit consumes operands
- a_out  out  16  registered A operand
- b_out  out  16  registered B operand
- fs_out  out  fs_t  registered function select
- rw_out  out  1  registered write flag
- da_out  out  3  registered destination
- wb_en_in  in  1  write-back strobe
- wb_addr_in  in  3  write-back register
- wb_data_in  in  16  write-back data

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, fu_valid_out 0, a_out/b_out 0, fs_out FMOVA, rw_out 0, da_out 0.
- Register file: written on posedge clk when wb_en_in.
- Combinational read with bypass: if wb_en_in and wb_addr_in matches the source address, the read returns wb_data_in.
- Scoreboard busy[NREGS]:
  - Set: busy[da_in] is set on accept when rw_in=1.
  - Clear: busy[wb_addr_in] is cleared on wb_en_in.
  - Same address, same cycle: set wins.
  - wb_en_in to a non-busy register is legal; it writes and busy stays 0.
- Hazard (combinational):
  - RAW: busy[aa_in] and the source is not being written back this cycle.
  - RAW: !mb_in and busy[ba_in] and not being written back this cycle.
  - WAW: rw_in and busy[da_in], regardless of write-back.
- id_ready_out = (!fu_valid_out | fu_ready_in) & !hazard.
  - Depends combinationally on id address inputs.
  - Never depends on id_valid_in.
- Accept = id_valid_in & id_ready_out.
  - Next cycle: fu_valid_out=1 and output registers loaded.
  - Latency: one cycle, accept to fu_valid_out.
- fu_valid_out & fu_ready_in without accept: fu_valid_out drops to 0; output registers hold their values.
- fu_valid_out & !fu_ready_in: all outputs stable.
- Throughput: one instruction per cycle when hazard-free and fu_ready_in=1.
- Reset mid-operation: in-flight instruction discarded; scoreboard cleared.

Optional Feature:
- Macro: OF_R0_ZERO_EN.
- Defined:
  - R0 always reads 0, including through the bypass.
  - Writes to R0 are ignored.
  - busy[0] is never set; rw_in with da_in=0 never causes a WAW stall.
- Undefined: R0 is an ordinary register.

Decomposition:
- mycpu_pkg: fs_t (existing), REG_AW=3 constant, register-address typedef reg_t.
- One sub-module, of_regfile: storage plus bypassed dual read port.
- Scoreboard, hazard logic and pipeline register stay in of_stage.

Test Plan:
- Reset, then issue FADD aa=1 ba=2 after wb writes R1=0x0005, R2=0x0003 → next cycle fu_valid_out=1, a_out=0x0005, b_out=0x0003, fs_out=FADD.
- RAW: accept rw=1 da=3, then instruction with aa=3 → id_ready_out=0 until wb_en R3=0x1234.
  - In the wb cycle, ready=1 via bypass.
  - Next cycle a_out=0x1234.
- WAW: busy R4, present rw=1 da=4 with wb_en R4 same cycle → stalls that cycle; accepted the following cycle.
- Backpressure: fu_ready_in=0 for 3 cycles with id_valid_in=1 → outputs frozen, id_ready_out=0.
  - After fu_ready_in rises, back-to-back accepts, one per cycle.
- mb_in=1, const_in=0xFFFF, ba_in=busy register → no stall, b_out=0xFFFF.
- Assert rst_n low with fu_valid_out=1 and busy bits set → fu_valid_out=0 and busy cleared immediately.
  - With OF_R0_ZERO_EN: wb R0=0x00AA, then read aa=0 → a_out=0x0000.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared CPU definitions: function-select encoding, register-address type,
// and a small helper used by the R0-hardwired-zero option (OF_R0_ZERO_EN).
package mycpu_pkg;

    localparam int REG_AW = 3;

    typedef logic [REG_AW-1:0] reg_t;

    typedef enum logic [3:0] {
        FMOVA = 4'd0,
        FINC  = 4'd1,
        FADD  = 4'd2,
        FADDC = 4'd3,
        FSUB  = 4'd4,
        FDEC  = 4'd5,
        FAND  = 4'd6,
        FOR   = 4'd7,
        FXOR  = 4'd8,
        FNOT  = 4'd9,
        FMOVB = 4'd10,
        FSHR  = 4'd11,
        FSHL  = 4'd12
    } fs_t;

    // True when the address names R0.
    function automatic logic is_r0(input reg_t r);
        return (r == {REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/of_regfile.sv
// Register file with one write port and two combinational read ports.
// A read of the register being written this cycle returns the write data.
// Macro OF_R0_ZERO_EN: R0 reads as zero and ignores writes.
module of_regfile
    import mycpu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  reg_t          ra_a_in,
    input  reg_t          ra_b_in,
    output logic [DW-1:0] rd_a_out,
    output logic [DW-1:0] rd_b_out,
    input  logic          we_in,
    input  reg_t          wa_in,
    input  logic [DW-1:0] wd_in
);

`ifdef OF_R0_ZERO_EN
    localparam logic R0_ZERO = 1'b1;
`else
    localparam logic R0_ZERO = 1'b0;
`endif

    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];
    logic          we_s;

    // Next-state of the storage array: write the addressed entry on a strobe.
    always_comb begin
        regs_d = regs_q;
        we_s   = we_in & ~(R0_ZERO & is_r0(wa_in));
        if (we_s) begin
            regs_d[wa_in] = wd_in;
        end else begin
            regs_d[wa_in] = regs_q[wa_in];
        end
    end

    // Storage flops, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DW{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port A with write-back bypass; hardwired R0 has top priority.
    always_comb begin
        rd_a_out = regs_q[ra_a_in];
        if (R0_ZERO && is_r0(ra_a_in)) begin
            rd_a_out = {DW{1'b0}};
        end else if (we_in && (wa_in == ra_a_in)) begin
            rd_a_out = wd_in;
        end else begin
            rd_a_out = regs_q[ra_a_in];
        end
    end

    // Read port B with write-back bypass; hardwired R0 has top priority.
    always_comb begin
        rd_b_out = regs_q[ra_b_in];
        if (R0_ZERO && is_r0(ra_b_in)) begin
            rd_b_out = {DW{1'b0}};
        end else if (we_in && (wa_in == ra_b_in)) begin
            rd_b_out = wd_in;
        end else begin
            rd_b_out = regs_q[ra_b_in];
        end
    end

endmodule

// File: rtl/of_stage.sv
// Operand-fetch stage: register file read, busy-bit scoreboard for RAW/WAW
// hazards, and the single pipeline register feeding the function unit.
// Macro OF_R0_ZERO_EN: R0 is hardwired to zero and never marked busy.
module of_stage
    import mycpu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid_in,
    output logic          id_ready_out,
    input  reg_t          aa_in,
    input  reg_t          ba_in,
    input  logic          mb_in,
    input  logic [DW-1:0] const_in,
    input  fs_t           fs_in,
    input  logic          rw_in,
    input  reg_t          da_in,
    output logic          fu_valid_out,
    input  logic          fu_ready_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output fs_t           fs_out,
    output logic          rw_out,
    output reg_t          da_out,
    input  logic          wb_en_in,
    input  reg_t          wb_addr_in,
    input  logic [DW-1:0] wb_data_in
);

`ifdef OF_R0_ZERO_EN
    localparam logic R0_ZERO = 1'b1;
`else
    localparam logic R0_ZERO = 1'b0;
`endif

    logic [DW-1:0]    rd_a_s, rd_b_s;
    logic [NREGS-1:0] busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [DW-1:0]    a_q, a_d, b_q, b_d;
    fs_t              fs_q, fs_d;
    logic             rw_q, rw_d;
    reg_t             da_q, da_d;
    logic             raw_a_s, raw_b_s, waw_s, hazard_s, ready_s, accept_s;

    of_regfile #(.NREGS(NREGS), .DW(DW)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_a_in  (aa_in),
        .ra_b_in  (ba_in),
        .rd_a_out (rd_a_s),
        .rd_b_out (rd_b_s),
        .we_in    (wb_en_in),
        .wa_in    (wb_addr_in),
        .wd_in    (wb_data_in)
    );

    // Hazard detection and handshake; a write-back in flight resolves RAW but not WAW.
    always_comb begin
        raw_a_s  = busy_q[aa_in] & ~(wb_en_in & (wb_addr_in == aa_in));
        raw_b_s  = ~mb_in & busy_q[ba_in] & ~(wb_en_in & (wb_addr_in == ba_in));
        waw_s    = rw_in & busy_q[da_in];
        hazard_s = raw_a_s | raw_b_s | waw_s;
        ready_s  = (~valid_q | fu_ready_in) & ~hazard_s;
        accept_s = id_valid_in & ready_s;
    end

    // Scoreboard next state: write-back clears, an accepted writer sets (set wins).
    always_comb begin
        busy_d = busy_q;
        if (wb_en_in) begin
            busy_d[wb_addr_in] = 1'b0;
        end else begin
            busy_d[wb_addr_in] = busy_q[wb_addr_in];
        end
        if (accept_s && rw_in && !(R0_ZERO && is_r0(da_in))) begin
            busy_d[da_in] = 1'b1;
        end else begin
            busy_d[da_in] = busy_d[da_in];
        end
    end

    // Pipeline register next state: load on accept, drop valid once consumed.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        fs_d    = fs_q;
        rw_d    = rw_q;
        da_d    = da_q;
        valid_d = valid_q;
        if (accept_s) begin
            a_d     = rd_a_s;
            b_d     = mb_in ? const_in : rd_b_s;
            fs_d    = fs_in;
            rw_d    = rw_in;
            da_d    = da_in;
            valid_d = 1'b1;
        end else if (fu_ready_in) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State flops for scoreboard and pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= {NREGS{1'b0}};
            valid_q <= 1'b0;
            a_q     <= {DW{1'b0}};
            b_q     <= {DW{1'b0}};
            fs_q    <= FMOVA;
            rw_q    <= 1'b0;
            da_q    <= {REG_AW{1'b0}};
        end else begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fs_q    <= fs_d;
            rw_q    <= rw_d;
            da_q    <= da_d;
        end
    end

    assign id_ready_out = ready_s;
    assign fu_valid_out = valid_q;
    assign a_out        = a_q;
    assign b_out        = b_q;
    assign fs_out       = fs_q;
    assign rw_out       = rw_q;
    assign da_out       = da_q;

endmodule

// File: tb/tb_of_stage.sv
// Scoreboard bench for of_stage: a driver keeps a behavioural model and
// queues expected operand bundles; a monitor compares what the stage presents.
module tb_of_stage;
    import mycpu_pkg::*;

`ifdef OF_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid_in, id_ready_out, mb_in, rw_in, fu_valid_out, fu_ready_in;
    reg_t        aa_in, ba_in, da_in, da_out, wb_addr_in;
    logic [15:0] const_in, a_out, b_out, wb_data_in;
    fs_t         fs_in, fs_out;
    logic        rw_out, wb_en_in;

    always #5 clk = ~clk;

    of_stage #(.NREGS(8), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_in(id_valid_in), .id_ready_out(id_ready_out),
        .aa_in(aa_in), .ba_in(ba_in), .mb_in(mb_in), .const_in(const_in),
        .fs_in(fs_in), .rw_in(rw_in), .da_in(da_in),
        .fu_valid_out(fu_valid_out), .fu_ready_in(fu_ready_in),
        .a_out(a_out), .b_out(b_out), .fs_out(fs_out), .rw_out(rw_out), .da_out(da_out),
        .wb_en_in(wb_en_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fs;
        logic        rw;
        logic [2:0]  da;
    } item_t;

    item_t       exp_q[$];
    logic [15:0] m_regs [8];
    bit          m_busy [8];
    bit          m_valid;
    int          checks = 0;
    int          errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] m_read(input reg_t r, input bit we, input reg_t wa, input logic [15:0] wd);
        if (R0Z && r == 3'd0) return 16'h0000;
        if (we && wa == r) return wd;
        return m_regs[r];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 16'h0000;
            m_busy[i] = 1'b0;
        end
        m_valid = 1'b0;
        exp_q.delete();
    endfunction

    // One cycle: drive inputs, check handshake against the model, update the model.
    task automatic step(input bit v, input reg_t aa, input reg_t ba, input bit mb,
                        input logic [15:0] k, input fs_t fs, input bit rw, input reg_t da,
                        input bit frdy, input bit we, input reg_t wa, input logic [15:0] wd);
        bit    hz, exp_rdy, acc;
        item_t it;
        @(negedge clk);
        id_valid_in = v; aa_in = aa; ba_in = ba; mb_in = mb; const_in = k;
        fs_in = fs; rw_in = rw; da_in = da; fu_ready_in = frdy;
        wb_en_in = we; wb_addr_in = wa; wb_data_in = wd;
        #2;
        hz = (m_busy[aa] && !(we && wa == aa))
          || (!mb && m_busy[ba] && !(we && wa == ba))
          || (rw && m_busy[da]);
        exp_rdy = (!m_valid || frdy) && !hz;
        chk("id_ready", {31'd0, id_ready_out}, {31'd0, exp_rdy});
        chk("fu_valid", {31'd0, fu_valid_out}, {31'd0, m_valid});
        acc = v && exp_rdy;
        if (acc) begin
            it.a  = m_read(aa, we, wa, wd);
            it.b  = mb ? k : m_read(ba, we, wa, wd);
            it.fs = fs;
            it.rw = rw;
            it.da = da;
            exp_q.push_back(it);
        end
        m_valid = acc ? 1'b1 : (frdy ? 1'b0 : m_valid);
        if (we && !(R0Z && wa == 3'd0)) m_regs[wa] = wd;
        if (we) m_busy[wa] = 1'b0;
        if (acc && rw && !(R0Z && da == 3'd0)) m_busy[da] = 1'b1;
    endtask

    task automatic idle(input bit frdy);
        step(1'b0, 3'd0, 3'd0, 1'b0, 16'h0, FMOVA, 1'b0, 3'd0, frdy, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_fu_valid", {31'd0, fu_valid_out}, 32'd0);
        chk("rst_a", {16'd0, a_out}, 32'd0);
        chk("rst_b", {16'd0, b_out}, 32'd0);
        chk("rst_fs", {28'd0, fs_out}, {28'd0, FMOVA});
        chk("rst_rw", {31'd0, rw_out}, 32'd0);
        chk("rst_da", {29'd0, da_out}, 32'd0);
    endtask

    // Asynchronous reset in the middle of a cycle.
    task automatic do_reset();
        @(negedge clk);
        id_valid_in = 1'b0;
        wb_en_in    = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare the presented bundle with the queue head; pop on consume.
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && fu_valid_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got a=%0h with nothing expected", a_out);
                end else begin
                    e = exp_q[0];
                    chk("a_out", {16'd0, a_out}, {16'd0, e.a});
                    chk("b_out", {16'd0, b_out}, {16'd0, e.b});
                    chk("fs_out", {28'd0, fs_out}, {28'd0, e.fs});
                    chk("rw_out", {31'd0, rw_out}, {31'd0, e.rw});
                    chk("da_out", {29'd0, da_out}, {29'd0, e.da});
                    if (fu_ready_in) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit          v, mb, rw, frdy, we;
        reg_t        aa, ba, da, wa;
        logic [15:0] k, wd;
        fs_t         fs;

        rst_n = 1'b0;
        id_valid_in = 1'b0; aa_in = 3'd0; ba_in = 3'd0; mb_in = 1'b0; const_in = 16'h0;
        fs_in = FMOVA; rw_in = 1'b0; da_in = 3'd0; fu_ready_in = 1'b1;
        wb_en_in = 1'b0; wb_addr_in = 3'd0; wb_data_in = 16'h0;
        model_clear();
        #3;
        check_reset_outputs();
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Basic FADD after two write-backs.
        step(1'b0, 3'd0, 3'd0, 1'b0, 16'h0, FMOVA, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 16'h0005);
        step(1'b0, 3'd0, 3'd0, 1'b0, 16'h0, FMOVA, 1'b0, 3'd0, 1'b1, 1'b1, 3'd2, 16'h0003);
        step(1'b1, 3'd1, 3'd2, 1'b0, 16'h0, FADD,  1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 16'h0);
        idle(1'b1);

        // RAW on R3, resolved through the bypass.
        step(1'b1, 3'd0, 3'd0, 1'b0, 16'h0, FMOVA, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 16'h0);
        step(1'b1, 3'd3, 3'd0, 1'b0, 16'h0, FINC,  1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 16'h0);
        step(1'b1, 3'd3, 3'd0, 1'b0, 16'h0, FINC,  1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 16'h0);
        step(1'b1, 3'd3, 3'd0, 1'b0, 16'h0, FINC,  1'b0, 3'd0, 1'b1, 1'b1, 3'd3, 16'h1234);
        idle(1'b1);

        // WAW on R4: stall during the write-back cycle, accept afterwards.
        step(1'b1, 3'd0, 3'd0, 1'b0, 16'h0, FMOVA, 1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 16'h0);
        step(1'b1, 3'd0, 3'd0, 1'b0, 16'h0, FSUB,  1'b1, 3'd4, 1'b1, 1'b1, 3'd4, 16'h0077);
        step(1'b1, 3'd0, 3'd0, 1'b0, 16'h0, FSUB,  1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 16'h0);
        step(1'b0, 3'd0, 3'd0, 1'b0, 16'h0, FMOVA, 1'b0, 3'd0, 1'b1, 1'b1, 3'd4, 16'h0088);

        // Backpressure for three cycles, then back-to-back accepts.
        step(1'b1, 3'd1, 3'd2, 1'b0, 16'h0, FAND, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'd2, 3'd1, 1'b0, 16'h0, FOR, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 3'(i), 3'(i + 1), 1'b0, 16'h0, FXOR, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 16'h0);

        // Immediate operand ignores a busy B source.
        step(1'b1, 3'd0, 3'd0, 1'b0, 16'h0,    FMOVA, 1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 16'h0);
        step(1'b1, 3'd1, 3'd5, 1'b1, 16'hFFFF, FMOVB, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 16'h0);

        // Reset while an instruction is presented and R5 is busy.
        step(1'b1, 3'd0, 3'd0, 1'b0, 16'h0, FMOVA, 1'b1, 3'd6, 1'b0, 1'b0, 3'd0, 16'h0);
        do_reset();
        step(1'b1, 3'd5, 3'd6, 1'b0, 16'h0, FADD, 1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 16'h0);
        idle(1'b1);

        // Write-back to R0 followed by a read of R0.
        step(1'b0, 3'd0, 3'd0, 1'b0, 16'h0, FMOVA, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 16'h00AA);
        step(1'b1, 3'd0, 3'd0, 1'b0, 16'h0, FMOVA, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 16'h0);
        step(1'b1, 3'd0, 3'd0, 1'b0, 16'h0, FMOVA, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 16'h0);
        idle(1'b1);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) do_reset();
            v    = ($urandom_range(0, 3) != 0);
            aa   = 3'($urandom_range(0, 7));
            ba   = 3'($urandom_range(0, 7));
            da   = 3'($urandom_range(0, 7));
            mb   = ($urandom_range(0, 3) == 0);
            k    = 16'($urandom);
            fs   = fs_t'(4'($urandom_range(0, 12)));
            rw   = $urandom_range(0, 1) != 0;
            frdy = ($urandom_range(0, 3) != 0);
            we   = $urandom_range(0, 1) != 0;
            wa   = 3'($urandom_range(0, 7));
            for (int t = 0; t < 4 && !m_busy[wa]; t++) wa = 3'($urandom_range(0, 7));
            wd   = 16'($urandom);
            step(v, aa, ba, mb, k, fs, rw, da, frdy, we, wa, wd);
        end

        // Drain and confirm every expected bundle was presented.
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
